riscv_ctrl_mc_fsm: RTL and testbench
====================================

# riscv_ctrl_mc_fsm

Multi-cycle main controller for the RISC-V core. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It adds a ready/request memory handshake with unbounded wait states and a retired-instruction counter. It sits in the control unit beside the ALU decoder, which consumes `oalu_op`.

## Interface
- `P_INSTRET_W`, default 32: width of the retired-instruction counter.
- `iclk  in  1`: clock; all state changes on the rising edge.
- `irst_n  in  1`: asynchronous, active-low reset.
- `iop  in  7`: opcode field of the instruction register. Sampled in DECODE only.
- `imem_ready  in  1`: memory completes the current request in this cycle.
- `omem_req  out  1`: memory request. Held high until `imem_ready`.
- `omem_wr_en  out  1`: the request is a write.
- `oadr_src  out  1`: memory address select. 0 = PC, 1 = ALUOut.
- `oir_wr_en  out  1`: load the instruction register and the old-PC register.
- `opc_wr_en  out  1`: unconditional PC write.
- `obranch  out  1`: PC write is conditional on the zero/compare flag.
- `orf_wr_en  out  1`: register file write.
- `oalu_src_a  out  2`: ALU A select. 00 = PC, 01 = old PC, 10 = rs1.
- `oalu_src_b  out  2`: ALU B select. 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `oresult_src  out  2`: result select. 00 = ALUOut, 01 = memory data, 10 = ALUResult, 11 = ImmExt.
- `oimm_src  out  3`: immediate format. 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `oalu_op  out  2`: 00 = add, 01 = branch compare, 10 = decode by funct fields.
- `ostate  out  4`: current state encoding, for debug and verification.
- `oinstret  out  P_INSTRET_W`: count of retired instructions.

## Operation
- State encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMREAD = 4, MEMWB = 5, MEMWRITE = 6, EXECR = 7
  - EXECI = 8, ALUWB = 9, BRANCH = 10, JAL = 11, JALR = 12, LUI = 13, TRAP = 14.
- All outputs are 0 unless listed for the current state.
- IDLE: all outputs 0. Always moves to FETCH on the next cycle.
- FETCH:
  - Drives `omem_req`=1, `oadr_src`=0, `oalu_src_a`=00, `oalu_src_b`=10, `oresult_src`=10.
  - `oir_wr_en` and `opc_wr_en` equal `imem_ready`.
  - Moves to DECODE when `imem_ready`=1; otherwise stays in FETCH.
- DECODE:
  - `oalu_src_a`=01, `oalu_src_b`=01; ALUOut becomes old PC + imm.
  - `oimm_src` is set by `iop`: B for branch, J for jal, U for lui/auipc, I otherwise.
- Transitions out of DECODE by `iop`:
  - 0x03 or 0x23 goes to MEMADR.
  - 0x33 goes to EXECR; 0x13 goes to EXECI; 0x63 goes to BRANCH.
  - 0x6F goes to JAL; 0x67 goes to JALR; 0x37 goes to LUI.
  - 0x17 goes directly to ALUWB.
  - Any other opcode: see Configuration.
- MEMADR:
  - `oalu_src_a`=10, `oalu_src_b`=01. `oimm_src` is S for stores and I for loads.
  - Moves to MEMREAD for a load, MEMWRITE for a store.
  - The opcode class is latched in DECODE; `iop` is not re-sampled here.
- MEMREAD: `omem_req`=1, `oadr_src`=1. Moves to MEMWB on `imem_ready`, otherwise waits.
- MEMWB: `oresult_src`=01, `orf_wr_en`=1. Moves to FETCH.
- MEMWRITE: `omem_req`=1, `omem_wr_en`=1, `oadr_src`=1. Moves to FETCH on `imem_ready`, otherwise waits.
- EXECR: `oalu_src_a`=10, `oalu_src_b`=00, `oalu_op`=10. Moves to ALUWB.
- EXECI: same as EXECR but `oalu_src_b`=01. Moves to ALUWB.
- ALUWB: `oresult_src`=00, `orf_wr_en`=1. Moves to FETCH.
- BRANCH: `oalu_src_a`=10, `oalu_src_b`=00, `oalu_op`=01, `oresult_src`=00, `obranch`=1. Moves to FETCH.
- JAL: `oalu_src_a`=01, `oalu_src_b`=10, `oresult_src`=00, `opc_wr_en`=1. Moves to ALUWB, which writes old PC + 4 to rd.
- JALR: `oalu_src_a`=10, `oalu_src_b`=01, `oimm_src`=I. Moves to JAL.
- LUI: `oresult_src`=11, `oimm_src`=U, `orf_wr_en`=1. Moves to FETCH.
- Retire rule:
  - `oinstret` increments by 1 on every transition into FETCH from any state other than IDLE.
  - Wraps from all-ones to 0.

## Timing
- Reset:
  - State goes to IDLE immediately on `irst_n` low, independent of the clock.
  - `oinstret` resets to 0; every output is 0.
- Reset asserted mid-operation (including during a memory wait) abandons the instruction with no retire.
- Cycles per instruction with zero memory wait states:
  - lui, auipc, branch: 3.
  - R-type, I-type, store, jal: 4.
  - load, jalr: 5.
- Each cycle `imem_ready` is held low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `imem_ready` is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- `omem_req` stays high and the address select stays stable for the whole wait.

## Configuration
- Macro `RISCV_CTRL_MC_TRAP_EN`.
- Defined:
  - An unrecognised opcode in DECODE moves to TRAP.
  - TRAP drives all outputs 0 and holds until reset.
  - No retire is counted.
- Undefined:
  - An unrecognised opcode moves from DECODE to FETCH as a NOP and counts as retired.
  - The TRAP encoding is unreachable.

## Test plan
- Reset release, `imem_ready` tied to 1, R-type opcode 0x33 → `ostate` sequence 0, 1, 2, 7, 9, 1. `orf_wr_en` high only in ALUWB. `oinstret`=1.
- Load 0x03 with `imem_ready` low for 3 cycles in MEMREAD → 8 cycles FETCH to FETCH. `omem_req` and `oadr_src`=1 are held for all 4 MEMREAD cycles.
- jalr 0x67 → sequence 2, 12, 11, 9, 1. `opc_wr_en`=1 only in JAL.
- `irst_n` pulsed low during FETCH wait → `ostate` 0 immediately, `oinstret` 0, `omem_req` 0.
- Opcode 0x7F:
  - With `RISCV_CTRL_MC_TRAP_EN`: `ostate` stays 14, `oinstret` unchanged.
  - Without it: returns to 1 and `oinstret` increments.
- `P_INSTRET_W`=4, 16 lui instructions → `oinstret` wraps 15 → 0.

Source files
------------

// File: rtl/riscv_ctrl_mc_fsm.sv
// riscv_ctrl_mc_fsm: multi-cycle Moore controller for the RISC-V core.
// It sequences fetch / decode / execute / memory / writeback over one shared
// ALU and one memory port. It also provides a ready/request memory handshake
// and a retired-instruction counter.
//
// Optional feature: define RISCV_CTRL_MC_TRAP_EN to route unrecognised
// opcodes to a sticky TRAP state. Otherwise they retire as NOPs.
//
// Ports:
//   iclk, irst_n       clock, asynchronous active-low reset
//   iop[6:0]           opcode field of the instruction register (used in DECODE)
//   imem_ready         memory completes the current request this cycle
//   omem_req           memory request (held until imem_ready)
//   omem_wr_en         the request is a write
//   oadr_src           memory address select: 0 = PC, 1 = ALUOut
//   oir_wr_en          load the instruction register and the old-PC register
//   opc_wr_en          unconditional PC write
//   obranch            PC write conditional on the compare flag
//   orf_wr_en          register file write
//   oalu_src_a[1:0]    00 = PC, 01 = old PC, 10 = rs1
//   oalu_src_b[1:0]    00 = rs2, 01 = ImmExt, 10 = constant 4
//   oresult_src[1:0]   00 = ALUOut, 01 = mem data, 10 = ALUResult, 11 = ImmExt
//   oimm_src[2:0]      000 = I, 001 = S, 010 = B, 011 = J, 100 = U
//   oalu_op[1:0]       00 = add, 01 = branch compare, 10 = funct decode
//   ostate[3:0]        current state encoding (debug)
//   oinstret           retired-instruction count, wraps
module riscv_ctrl_mc_fsm #(
  parameter int unsigned P_INSTRET_W = 32
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic [6:0]             iop,
  input  logic                   imem_ready,
  output logic                   omem_req,
  output logic                   omem_wr_en,
  output logic                   oadr_src,
  output logic                   oir_wr_en,
  output logic                   opc_wr_en,
  output logic                   obranch,
  output logic                   orf_wr_en,
  output logic [1:0]             oalu_src_a,
  output logic [1:0]             oalu_src_b,
  output logic [1:0]             oresult_src,
  output logic [2:0]             oimm_src,
  output logic [1:0]             oalu_op,
  output logic [3:0]             ostate,
  output logic [P_INSTRET_W-1:0] oinstret
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t                 state_q, state_d;
  logic                   is_store_q;
  logic                   retire_c;
  logic [P_INSTRET_W-1:0] instret_q;

  // State register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load/store class is captured in DECODE so MEMADR never looks at iop again
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      is_store_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      is_store_q <= (iop == OP_STORE);
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = state_q;
    omem_req    = 1'b0;
    omem_wr_en  = 1'b0;
    oadr_src    = 1'b0;
    oir_wr_en   = 1'b0;
    opc_wr_en   = 1'b0;
    obranch     = 1'b0;
    orf_wr_en   = 1'b0;
    oalu_src_a  = 2'b00;
    oalu_src_b  = 2'b00;
    oresult_src = 2'b00;
    oimm_src    = IMM_I;
    oalu_op     = 2'b00;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        omem_req    = 1'b1;
        oalu_src_b  = 2'b10;
        oresult_src = 2'b10;
        oir_wr_en   = imem_ready;
        opc_wr_en   = imem_ready;
        if (imem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        oalu_src_a = 2'b01;
        oalu_src_b = 2'b01;
        case (iop)
          OP_BRANCH:         oimm_src = IMM_B;
          OP_JAL:            oimm_src = IMM_J;
          OP_LUI, OP_AUIPC:  oimm_src = IMM_U;
          default:           oimm_src = IMM_I;
        endcase
        case (iop)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
`ifdef RISCV_CTRL_MC_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end

      S_MEMADR: begin
        oalu_src_a = 2'b10;
        oalu_src_b = 2'b01;
        oimm_src   = is_store_q ? IMM_S : IMM_I;
        state_d    = is_store_q ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        omem_req = 1'b1;
        oadr_src = 1'b1;
        if (imem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        oresult_src = 2'b01;
        orf_wr_en   = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEMWRITE: begin
        omem_req   = 1'b1;
        omem_wr_en = 1'b1;
        oadr_src   = 1'b1;
        if (imem_ready) state_d = S_FETCH;
      end

      S_EXECR: begin
        oalu_src_a = 2'b10;
        oalu_op    = 2'b10;
        state_d    = S_ALUWB;
      end

      S_EXECI: begin
        oalu_src_a = 2'b10;
        oalu_src_b = 2'b01;
        oalu_op    = 2'b10;
        state_d    = S_ALUWB;
      end

      S_ALUWB: begin
        orf_wr_en = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        oalu_src_a = 2'b10;
        oalu_op    = 2'b01;
        obranch    = 1'b1;
        state_d    = S_FETCH;
      end

      // ALUOut still holds old PC + imm (jal) or rs1 + imm (jalr) here
      S_JAL: begin
        oalu_src_a = 2'b01;
        oalu_src_b = 2'b10;
        opc_wr_en  = 1'b1;
        state_d    = S_ALUWB;
      end

      S_JALR: begin
        oalu_src_a = 2'b10;
        oalu_src_b = 2'b01;
        state_d    = S_JAL;
      end

      S_LUI: begin
        oresult_src = 2'b11;
        oimm_src    = IMM_U;
        orf_wr_en   = 1'b1;
        state_d     = S_FETCH;
      end

`ifdef RISCV_CTRL_MC_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Waiting in FETCH and the first fetch after IDLE are not retirements
  assign retire_c = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);

  // Retired-instruction counter
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      instret_q <= '0;
    end else if (retire_c) begin
      instret_q <= instret_q + P_INSTRET_W'(1);
    end
  end

  assign ostate   = 4'(state_q);
  assign oinstret = instret_q;

endmodule

// File: tb/tb_riscv_ctrl_mc_fsm.sv
// Testbench for riscv_ctrl_mc_fsm. The reference model expands each
// instruction into its expected list of visited states from the opcode and
// the wait-state counts. It also carries a per-state output table and a
// simple retire counter. A second instance with a 4-bit counter is checked
// for wrap-around.
module tb_riscv_ctrl_mc_fsm;

  logic        iclk;
  logic        irst_n;
  logic [6:0]  iop;
  logic        imem_ready;

  logic        mem_req, mem_wr_en, adr_src, ir_wr_en, pc_wr_en, branch, rf_wr_en;
  logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0]  imm_src;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        n_mem_req, n_mem_wr_en, n_adr_src, n_ir_wr_en, n_pc_wr_en, n_branch, n_rf_wr_en;
  logic [1:0]  n_alu_src_a, n_alu_src_b, n_result_src, n_alu_op;
  logic [2:0]  n_imm_src;
  logic [3:0]  n_state;
  logic [3:0]  n_instret;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;

  riscv_ctrl_mc_fsm #(.P_INSTRET_W(32)) dut (
    .iclk(iclk), .irst_n(irst_n), .iop(iop), .imem_ready(imem_ready),
    .omem_req(mem_req), .omem_wr_en(mem_wr_en), .oadr_src(adr_src),
    .oir_wr_en(ir_wr_en), .opc_wr_en(pc_wr_en), .obranch(branch),
    .orf_wr_en(rf_wr_en), .oalu_src_a(alu_src_a), .oalu_src_b(alu_src_b),
    .oresult_src(result_src), .oimm_src(imm_src), .oalu_op(alu_op),
    .ostate(state), .oinstret(instret)
  );

  riscv_ctrl_mc_fsm #(.P_INSTRET_W(4)) dut_narrow (
    .iclk(iclk), .irst_n(irst_n), .iop(iop), .imem_ready(imem_ready),
    .omem_req(n_mem_req), .omem_wr_en(n_mem_wr_en), .oadr_src(n_adr_src),
    .oir_wr_en(n_ir_wr_en), .opc_wr_en(n_pc_wr_en), .obranch(n_branch),
    .orf_wr_en(n_rf_wr_en), .oalu_src_a(n_alu_src_a), .oalu_src_b(n_alu_src_b),
    .oresult_src(n_result_src), .oimm_src(n_imm_src), .oalu_op(n_alu_op),
    .ostate(n_state), .oinstret(n_instret)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected control outputs per state, straight from the state descriptions
  function automatic logic [17:0] exp_outs(input int s, input logic rdy, input logic [6:0] op);
    logic       req, wr, adr, ir, pc, br, rf;
    logic [1:0] a, b, res, aop;
    logic [2:0] imm;
    {req, wr, adr, ir, pc, br, rf} = 7'b0;
    a = 2'd0; b = 2'd0; res = 2'd0; aop = 2'd0; imm = 3'd0;
    case (s)
      1:  begin req = 1; b = 2; res = 2; ir = rdy; pc = rdy; end
      2:  begin
            a = 1; b = 1;
            if (op == 7'h63) imm = 3'd2;
            else if (op == 7'h6F) imm = 3'd3;
            else if (op == 7'h37 || op == 7'h17) imm = 3'd4;
          end
      3:  begin a = 2; b = 1; imm = (op == 7'h23) ? 3'd1 : 3'd0; end
      4:  begin req = 1; adr = 1; end
      5:  begin res = 1; rf = 1; end
      6:  begin req = 1; wr = 1; adr = 1; end
      7:  begin a = 2; aop = 2; end
      8:  begin a = 2; b = 1; aop = 2; end
      9:  rf = 1;
      10: begin a = 2; aop = 1; br = 1; end
      11: begin a = 1; b = 2; pc = 1; end
      12: begin a = 2; b = 1; end
      13: begin res = 3; imm = 3'd4; rf = 1; end
      default: ;
    endcase
    return {req, wr, adr, ir, pc, br, rf, a, b, res, imm, aop};
  endfunction

  function automatic logic [17:0] dut_outs();
    return {mem_req, mem_wr_en, adr_src, ir_wr_en, pc_wr_en, branch, rf_wr_en,
            alu_src_a, alu_src_b, result_src, imm_src, alu_op};
  endfunction

  task automatic check_cycle(input string tag, input int s, input logic rdy, input logic [6:0] op);
    check($sformatf("%s state", tag), 32'(state), 32'(s));
    check($sformatf("%s outs", tag), 32'(dut_outs()), 32'(exp_outs(s, rdy, op)));
    check($sformatf("%s instret", tag), instret, 32'(exp_count));
    check($sformatf("%s instret4", tag), 32'(n_instret), 32'(exp_count % 16));
  endtask

  task automatic do_reset();
    irst_n = 1'b0;
    repeat (2) @(negedge iclk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset outs", 32'(dut_outs()), 32'd0);
    check("reset instret", instret, 32'd0);
    exp_count = 0;
    @(negedge iclk);
    irst_n = 1'b1;
    imem_ready = 1'(($urandom));
    #1;
    check_cycle("idle", 0, imem_ready, 7'h00);
  endtask

  // One instruction: expand to the expected state walk, then step through it
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
    int  st_q[$];
    int  rd_q[$];
    bit  retires = 1'b1;
    logic rdy;
    for (int i = 0; i < wf; i++) begin st_q.push_back(1); rd_q.push_back(0); end
    st_q.push_back(1); rd_q.push_back(1);
    st_q.push_back(2); rd_q.push_back(2);
    case (op)
      7'h03: begin
               st_q.push_back(3); rd_q.push_back(2);
               for (int i = 0; i < wm; i++) begin st_q.push_back(4); rd_q.push_back(0); end
               st_q.push_back(4); rd_q.push_back(1);
               st_q.push_back(5); rd_q.push_back(2);
             end
      7'h23: begin
               st_q.push_back(3); rd_q.push_back(2);
               for (int i = 0; i < wm; i++) begin st_q.push_back(6); rd_q.push_back(0); end
               st_q.push_back(6); rd_q.push_back(1);
             end
      7'h33: begin st_q.push_back(7);  rd_q.push_back(2); st_q.push_back(9); rd_q.push_back(2); end
      7'h13: begin st_q.push_back(8);  rd_q.push_back(2); st_q.push_back(9); rd_q.push_back(2); end
      7'h63: begin st_q.push_back(10); rd_q.push_back(2); end
      7'h6F: begin st_q.push_back(11); rd_q.push_back(2); st_q.push_back(9); rd_q.push_back(2); end
      7'h67: begin
               st_q.push_back(12); rd_q.push_back(2);
               st_q.push_back(11); rd_q.push_back(2);
               st_q.push_back(9);  rd_q.push_back(2);
             end
      7'h37: begin st_q.push_back(13); rd_q.push_back(2); end
      7'h17: begin st_q.push_back(9);  rd_q.push_back(2); end
      default: begin
`ifdef RISCV_CTRL_MC_TRAP_EN
        for (int i = 0; i < 4; i++) begin st_q.push_back(14); rd_q.push_back(2); end
        retires = 1'b0;
`endif
      end
    endcase
    foreach (st_q[i]) begin
      @(negedge iclk);
      rdy = (rd_q[i] == 2) ? 1'(($urandom)) : 1'(rd_q[i]);
      imem_ready = rdy;
      // Opcode is only meaningful in DECODE; scramble it elsewhere
      iop = (st_q[i] == 2) ? op : 7'($urandom);
      #1;
      check_cycle($sformatf("op%02h step%0d", op, i), st_q[i], rdy, op);
    end
    if (retires) exp_count++;
  endtask

  // One observation cycle without issuing a new instruction
  task automatic observe(input string tag, input int s);
    @(negedge iclk);
    imem_ready = 1'b0;
    #1;
    check_cycle(tag, s, 1'b0, 7'h00);
  endtask

  logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};

  initial begin
    irst_n = 1'b0;
    iop = 7'h00;
    imem_ready = 1'b0;
    #2;
    check("async reset state", 32'(state), 32'd0);

    do_reset();
    run_instr(7'h33, 0, 0);
    run_instr(7'h03, 0, 3);
    run_instr(7'h67, 0, 0);
    run_instr(7'h23, 2, 1);

    // Reset pulsed in the middle of a FETCH wait
    for (int i = 0; i < 3; i++) begin
      @(negedge iclk);
      imem_ready = 1'b0;
      #1;
      check_cycle("fetch wait", 1, 1'b0, 7'h00);
    end
    #2;
    irst_n = 1'b0;
    #1;
    check("midreset state", 32'(state), 32'd0);
    check("midreset instret", instret, 32'd0);
    check("midreset mem_req", 32'(mem_req), 32'd0);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(0, 9)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    observe("after random", 1);

    // Narrow counter wrap: 16 lui from reset
    do_reset();
    for (int n = 0; n < 16; n++) run_instr(7'h37, 0, 0);
    observe("wrap", 1);
    check("wrap instret4 zero", 32'(n_instret), 32'd0);
    check("wrap instret16", instret, 32'd16);

    // Unrecognised opcode
    run_instr(7'h7F, 1, 0);
`ifdef RISCV_CTRL_MC_TRAP_EN
    observe("trap hold", 14);
    check("trap instret", instret, 32'd16);
    do_reset();
`else
    observe("nop retire", 1);
    check("nop instret", instret, 32'd17);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
